parser_ingress_arb: RTL and testbench

//  Packet-atomic round-robin arbiter sharing one message parser between NUM_PORTS ingress streams.

---
 rtl/parser_ingress_arb.sv | 168 ++++++++++++++++
 tb/tb_parser_ingress_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parser_ingress_arb.sv
// Packet-atomic round-robin arbiter feeding one message parser from NUM_PORTS ingress streams.
// Grant is locked from SOP to EOP; beats pass through a single output register stage.
module parser_ingress_arb #(
    parameter int NUM_PORTS   = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int EMPTY_WIDTH = 3,
    parameter int DROP_CNT_W  = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_sop,
    input  logic [NUM_PORTS-1:0]             req_eop,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_PORTS*EMPTY_WIDTH-1:0] req_empty,
    input  logic [NUM_PORTS-1:0]             req_error,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic                             out_valid,
    output logic                             out_sop,
    output logic                             out_eop,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [EMPTY_WIDTH-1:0]           out_empty,
    output logic                             out_error,
    input  logic                             out_ready,
    output logic [NUM_PORTS-1:0]             grant,
    output logic [DROP_CNT_W-1:0]            drop_cnt
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam logic IDLE = 1'b0;
    localparam logic PKT  = 1'b1;

    logic                   state_reg, state_next;
    logic [IDX_W-1:0]       rr_reg, rr_next;
    logic [IDX_W-1:0]       owner_reg, owner_next;
    logic [NUM_PORTS-1:0]   grant_reg, grant_next;
    logic [DROP_CNT_W-1:0]  drop_cnt_reg;
    logic                   out_valid_reg, out_sop_reg, out_eop_reg, out_error_reg;
    logic [DATA_WIDTH-1:0]  out_data_reg;
    logic [EMPTY_WIDTH-1:0] out_empty_reg;

    logic                   can_load, fire, drop_fire, win_found, drop_found;
    logic [IDX_W-1:0]       win_idx, drop_idx, sel_idx;
    logic [NUM_PORTS-1:0]   sop_cand, frame_err, ready_int;

    logic [DATA_WIDTH-1:0]  port_data  [NUM_PORTS];
    logic [EMPTY_WIDTH-1:0] port_empty [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_data[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign port_empty[gi] = req_empty[gi*EMPTY_WIDTH +: EMPTY_WIDTH];
        end
    endgenerate

    function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] p);
        return (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
    endfunction

    assign can_load  = !out_valid_reg || out_ready;
    assign sop_cand  = req_valid & req_sop;
    assign frame_err = req_valid & ~req_sop;

    // Descending loops so the last hit is the nearest port from rr (winner) or lowest index (drop).
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        drop_found = 1'b0;
        drop_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (sop_cand[(int'(rr_reg) + k) % NUM_PORTS]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(rr_reg) + k) % NUM_PORTS);
            end
            if (frame_err[k]) begin
                drop_found = 1'b1;
                drop_idx   = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        owner_next = owner_reg;
        grant_next = grant_reg;
        ready_int  = '0;
        fire       = 1'b0;
        drop_fire  = 1'b0;
        sel_idx    = owner_reg;
        if (state_reg == IDLE) begin
            sel_idx = win_idx;
            if (win_found && can_load) begin
                ready_int[win_idx] = 1'b1;
                fire = 1'b1;
                if (req_eop[win_idx]) begin
                    rr_next = next_port(win_idx);
                end else begin
                    state_next          = PKT;
                    owner_next          = win_idx;
                    grant_next          = '0;
                    grant_next[win_idx] = 1'b1;
                end
            end
            // Framing errors are discarded even while the output register is blocked.
            if (drop_found) begin
                ready_int[drop_idx] = 1'b1;
                drop_fire = 1'b1;
            end
        end else begin
            if (can_load) begin
                ready_int = grant_reg;
                fire      = req_valid[owner_reg];
            end
            if (fire && req_eop[owner_reg]) begin
                state_next = IDLE;
                rr_next    = next_port(owner_reg);
                grant_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            rr_reg        <= '0;
            owner_reg     <= '0;
            grant_reg     <= '0;
            drop_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_sop_reg   <= 1'b0;
            out_eop_reg   <= 1'b0;
            out_error_reg <= 1'b0;
            out_data_reg  <= '0;
            out_empty_reg <= '0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            owner_reg <= owner_next;
            grant_reg <= grant_next;
            if (drop_fire && drop_cnt_reg != '1)
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            if (fire) begin
                out_valid_reg <= 1'b1;
                out_sop_reg   <= req_sop[sel_idx];
                out_eop_reg   <= req_eop[sel_idx];
                out_error_reg <= req_error[sel_idx];
                out_data_reg  <= port_data[sel_idx];
                out_empty_reg <= port_empty[sel_idx];
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // Hold every requester off while reset is asserted.
    assign req_ready = ready_int & {NUM_PORTS{reset_n}};
    assign out_valid = out_valid_reg;
    assign out_sop   = out_sop_reg;
    assign out_eop   = out_eop_reg;
    assign out_data  = out_data_reg;
    assign out_empty = out_empty_reg;
    assign out_error = out_error_reg;
    assign grant     = grant_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_parser_ingress_arb.sv
// Directed bench for parser_ingress_arb: per-port beat queues drive the DUT and
// a scoreboard queue holds the beats expected at the parser side, in arbitration order.
module tb_parser_ingress_arb;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int EW = 3;
    localparam int CW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic          error;
        logic          drop;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [NP-1:0]     req_valid, req_sop, req_eop, req_error, req_ready;
    logic [NP*DW-1:0]  req_data;
    logic [NP*EW-1:0]  req_empty;
    logic              out_valid, out_sop, out_eop, out_error, out_ready;
    logic [DW-1:0]     out_data;
    logic [EW-1:0]     out_empty;
    logic [NP-1:0]     grant;
    logic [CW-1:0]     drop_cnt;

    // Second instance with a 2-bit drop counter for the saturation check.
    logic [1:0]        v2, ready2, grant2;
    logic              ov2, osop2, oeop2, oerr2;
    logic [DW-1:0]     odata2;
    logic [EW-1:0]     oempty2;
    logic [1:0]        drop2;

    parser_ingress_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .DROP_CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_sop(req_sop), .req_eop(req_eop),
        .req_data(req_data), .req_empty(req_empty), .req_error(req_error),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .out_empty(out_empty), .out_error(out_error),
        .out_ready(out_ready), .grant(grant), .drop_cnt(drop_cnt)
    );

    parser_ingress_arb #(.NUM_PORTS(2), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .DROP_CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .req_valid(v2), .req_sop(2'b00), .req_eop(2'b00),
        .req_data({2*DW{1'b0}}), .req_empty({2*EW{1'b0}}), .req_error(2'b00),
        .req_ready(ready2),
        .out_valid(ov2), .out_sop(osop2), .out_eop(oeop2),
        .out_data(odata2), .out_empty(oempty2), .out_error(oerr2),
        .out_ready(1'b1), .grant(grant2), .drop_cnt(drop2)
    );

    beat_t port_q [NP][$];
    beat_t exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] pack(input beat_t b);
        return {58'b0, b.sop, b.eop, b.data, b.empty, b.error};
    endfunction

    function automatic int pending();
        int n = exp_q.size();
        for (int p = 0; p < NP; p++) n += port_q[p].size();
        return n;
    endfunction

    task automatic add_pkt(input int p, input int n, input int tag, input bit push_exp);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data  = {8'(p), 8'(tag), 16'(i), 32'($urandom)};
            b.sop   = (i == 0);
            b.eop   = (i == n - 1);
            b.empty = b.eop ? 3'($urandom_range(0, 7)) : 3'd0;
            b.error = b.eop && (tag % 2 == 1);
            b.drop  = 1'b0;
            port_q[p].push_back(b);
            if (push_exp) exp_q.push_back(b);
        end
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_sop = '0; req_eop = '0; req_error = '0;
        req_data = '0; req_empty = '0;
    endtask

    // One clock: present queue heads, score any output beat, note grant on mid-packet accepts.
    task automatic step(input logic ordy);
        logic [NP-1:0] acc;
        beat_t b, e;
        @(negedge clk);
        out_ready = ordy;
        clear_inputs();
        for (int p = 0; p < NP; p++) begin
            if (port_q[p].size() > 0) begin
                b = port_q[p][0];
                req_valid[p] = 1'b1;
                req_sop[p]   = b.sop;
                req_eop[p]   = b.eop;
                req_error[p] = b.error;
                req_data[p*DW +: DW]  = b.data;
                req_empty[p*EW +: EW] = b.empty;
            end
        end
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {58'b0, out_sop, out_eop, out_data, out_empty, out_error}, 128'b0);
            end else begin
                e = exp_q.pop_front();
                check("beat", {58'b0, out_sop, out_eop, out_data, out_empty, out_error}, pack(e));
                $display("beat data=%0h sop=%0b eop=%0b", out_data, out_sop, out_eop);
            end
        end
        acc = req_valid & req_ready;
        for (int p = 0; p < NP; p++) begin
            if (acc[p] && !port_q[p][0].sop && !port_q[p][0].drop)
                check("grant_onehot", 128'(grant), 128'(4'b0001 << p));
        end
        @(posedge clk);
        for (int p = 0; p < NP; p++)
            if (acc[p]) void'(port_q[p].pop_front());
    endtask

    task automatic run_until_done(input int budget, output int steps);
        steps = 0;
        while (pending() > 0 && steps < budget) begin
            step(1'b1);
            steps++;
        end
        check("drained", 128'(pending()), 128'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        for (int p = 0; p < NP; p++) port_q[p].delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int steps;
        beat_t b;

        // 1: reset with every port requesting
        reset_n = 1'b0; out_ready = 1'b1; v2 = 2'b00;
        req_valid = '1; req_sop = 4'b0101; req_eop = '0; req_error = '0;
        req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_empty = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_grant", 128'(grant), 128'd0);
        check("rst_drop_cnt", 128'(drop_cnt), 128'd0);
        check("rst_req_ready", 128'(req_ready), 128'd0);
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;

        // 4: framing drops on port 2
        b.data = 64'hDEAD; b.sop = 1'b0; b.eop = 1'b0; b.empty = '0; b.error = 1'b0; b.drop = 1'b1;
        repeat (3) port_q[2].push_back(b);
        repeat (3) begin
            step(1'b1);
            #1;
            check("drop_no_out", 128'(out_valid), 128'd0);
        end
        check("drop_cnt_3", 128'(drop_cnt), 128'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v2 = 2'b01;
            @(posedge clk);
            #1;
            check("drop_sat", 128'(drop2), 128'((i + 1 > 3) ? 3 : i + 1));
        end
        v2 = 2'b00;

        // 2: round-robin fairness, two 3-beat packets per port
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++)
                add_pkt(p, 3, r * NP + p, 1'b1);
        run_until_done(200, steps);

        // 3: backpressure mid-packet
        add_pkt(1, 6, 9, 1'b1);
        repeat (3) step(1'b1);
        repeat (5) begin
            step(1'b0);
            #1;
            check("bp_ready", 128'(req_ready), 128'd0);
            check("bp_valid", 128'(out_valid), 128'd1);
            check("bp_data", 128'(out_data), 128'(exp_q[0].data));
        end
        run_until_done(50, steps);

        // 5: single-beat packets from ports 1 and 3, one per cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            add_pkt(1, 1, 20 + i, 1'b1);
            add_pkt(3, 1, 30 + i, 1'b1);
        end
        begin
            beat_t tmp [$];
            // Reorder the scoreboard to alternate 1,3,1,3 as the arbiter should.
            tmp = exp_q;
            exp_q.delete();
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(tmp[2*i]);
                exp_q.push_back(tmp[2*i+1]);
            end
        end
        run_until_done(50, steps);
        check("single_beat_rate", 128'(steps), 128'd9);

        // 6: reset after beat 2 of a 4-beat packet on port 1 (abandon it)
        add_pkt(1, 4, 40, 1'b0);
        exp_q.push_back(port_q[1][0]);
        step(1'b1);
        step(1'b1);
        do_reset();
        #1;
        check("mid_rst_grant", 128'(grant), 128'd0);
        check("mid_rst_valid", 128'(out_valid), 128'd0);
        check("mid_rst_scoreboard", 128'(exp_q.size()), 128'd0);
        add_pkt(0, 1, 50, 1'b1);
        add_pkt(2, 1, 51, 1'b1);
        run_until_done(50, steps);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
